uart_can_frame_packer: RTL and testbench

UART_CAN_FRAME_PACKER -- requirements
Module: uart_can_frame_packer

---
 rtl/uart_can_frame_packer.sv | 114 +++++++++++
 tb/tb_uart_can_frame_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_can_frame_packer.sv
// Packs received UART bytes into CAN frames: an 8-byte assembly buffer feeding a holding register.
// Define FRAME_TIMEOUT_EN to flush partial frames after TIMEOUT_TICKS idle R_byte ticks.
module uart_can_frame_packer #(
  parameter logic [11:0] CAN_ID        = 12'h20D,
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_data_ready,
  input  logic [7:0]  uart_rx_data_bus,
  input  logic        R_byte,
  input  logic        frame_ack,
  output logic [11:0] Can_ID_Bus,
  output logic [63:0] can_tx_data_bus,
  output logic [3:0]  frame_dlc,
  output logic        Load_frame_datareg,
  output logic        Frame_ready,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [63:0] buffer, buffer_nxt;
  logic        flush;
  logic        transfer;
  logic        accept;

`ifdef FRAME_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_TICKS);

  logic [7:0] idle_cnt, idle_cnt_nxt;

  assign flush = (state == COLLECT) && (idle_cnt == TIMEOUT);

  // Saturating at TIMEOUT keeps the flush request alive while holding is still occupied.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (transfer || accept || state != COLLECT)
      idle_cnt_nxt = '0;
    else if (R_byte && idle_cnt != TIMEOUT)
      idle_cnt_nxt = idle_cnt + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) idle_cnt <= '0;
    else       idle_cnt <= idle_cnt_nxt;
  end
`else
  logic r_byte_unused;

  assign r_byte_unused = R_byte;
  assign flush         = 1'b0;
`endif

  assign transfer = (state == FULL || flush) && !Frame_ready;
  // A byte landing in the transfer cycle starts the next frame instead of being dropped.
  assign accept   = uart_data_ready && (state != FULL || transfer);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    buffer_nxt = buffer;
    if (transfer) begin
      state_nxt  = IDLE;
      count_nxt  = '0;
      buffer_nxt = '0;
    end
    if (accept) begin
      buffer_nxt[{3'd7 - count_nxt[2:0], 3'b000} +: 8] = uart_rx_data_bus;
      state_nxt = (count_nxt == 4'd7) ? FULL : COLLECT;
      count_nxt = count_nxt + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the buffer is plain flops, so it is reset too.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      buffer <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      buffer <= buffer_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Can_ID_Bus         <= '0;
      can_tx_data_bus    <= '0;
      frame_dlc          <= '0;
      Frame_ready        <= 1'b0;
      Load_frame_datareg <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      Load_frame_datareg <= transfer;
      if (transfer) begin
        Can_ID_Bus      <= CAN_ID;
        can_tx_data_bus <= buffer;
        frame_dlc       <= count;
        Frame_ready     <= 1'b1;
      end else if (frame_ack && Frame_ready) begin
        Frame_ready <= 1'b0;
      end
      if (uart_data_ready && !accept)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_can_frame_packer.sv
// Self-checking bench for uart_can_frame_packer: vector table, directed corner sequences and
// randomized traffic compared each cycle against a queue-based frame model.
module tb_uart_can_frame_packer;

  localparam logic [11:0] CAN_ID        = 12'h20D;
  localparam int          TIMEOUT_TICKS = 16;
`ifdef FRAME_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, uart_data_ready, R_byte, frame_ack;
  logic [7:0]  uart_rx_data_bus;
  logic [11:0] Can_ID_Bus;
  logic [63:0] can_tx_data_bus;
  logic [3:0]  frame_dlc;
  logic        Load_frame_datareg, Frame_ready, overrun;

  always #5 clock = ~clock;

  uart_can_frame_packer #(.CAN_ID(CAN_ID), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .clock             (clock),
    .reset             (reset),
    .uart_data_ready   (uart_data_ready),
    .uart_rx_data_bus  (uart_rx_data_bus),
    .R_byte            (R_byte),
    .frame_ack         (frame_ack),
    .Can_ID_Bus        (Can_ID_Bus),
    .can_tx_data_bus   (can_tx_data_bus),
    .frame_dlc         (frame_dlc),
    .Load_frame_datareg(Load_frame_datareg),
    .Frame_ready       (Frame_ready),
    .overrun           (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int load_seen = 0;

  // Reference model: bytes waiting to be framed, plus the frame currently offered to CAN.
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_valid, m_load, m_ovr;
  logic [63:0] m_data;
  logic [3:0]  m_dlc;
  logic [11:0] m_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit rdy, input logic [7:0] d, input bit rb, input bit ack);
    int  size;
    bit  partial, fl, xfer, acc;
    if (r) begin
      m_q.delete();
      m_idle = 0; m_valid = 0; m_load = 0; m_ovr = 0;
      m_data = '0; m_dlc = '0; m_id = '0;
      return;
    end
    size    = m_q.size();
    partial = (size >= 1 && size <= 7);
    fl      = TO_EN && partial && (m_idle == TIMEOUT_TICKS);
    xfer    = (size == 8 || fl) && !m_valid;
    acc     = rdy && (size != 8 || xfer);
    if (xfer || acc || !partial) m_idle = 0;
    else if (rb && m_idle < TIMEOUT_TICKS) m_idle++;
    m_load = xfer;
    if (xfer) begin
      m_data = '0;
      for (int k = 0; k < size; k++) m_data[63-8*k -: 8] = m_q[k];
      m_dlc   = 4'(size);
      m_id    = CAN_ID;
      m_valid = 1;
      m_q.delete();
    end else if (ack && m_valid) begin
      m_valid = 0;
    end
    if (acc) m_q.push_back(d);
    else if (rdy) m_ovr = 1;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge.
  task automatic tick(input bit r, input bit rdy, input logic [7:0] d, input bit rb, input bit ack);
    reset = r; uart_data_ready = rdy; uart_rx_data_bus = d; R_byte = rb; frame_ack = ack;
    @(posedge clock);
    model_step(r, rdy, d, rb, ack);
    @(negedge clock);
    if (Load_frame_datareg === 1'b1) load_seen++;
    check("Frame_ready", Frame_ready, m_valid);
    check("Load_frame_datareg", Load_frame_datareg, m_load);
    check("overrun", overrun, m_ovr);
    check("frame_dlc", frame_dlc, m_dlc);
    check("can_tx_data_bus", can_tx_data_bus, m_data);
    check("Can_ID_Bus", Can_ID_Bus, m_id);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] d);
    tick(0, 1, d, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " Frame_ready"}, Frame_ready, 1'b0);
    check({tag, " Load_frame_datareg"}, Load_frame_datareg, 1'b0);
    check({tag, " overrun"}, overrun, 1'b0);
    check({tag, " frame_dlc"}, frame_dlc, 4'd0);
    check({tag, " can_tx_data_bus"}, can_tx_data_bus, 64'h0);
    check({tag, " Can_ID_Bus"}, Can_ID_Bus, 12'h0);
  endtask

  typedef struct {
    bit         rst, rdy, ack;
    logic [7:0] d;
    bit         e_ready, e_load, chk_data;
  } vec_t;

  vec_t tbl[15];

  initial begin
    reset = 1; uart_data_ready = 0; uart_rx_data_bus = '0; R_byte = 0; frame_ack = 0;

    // Back-to-back 8-byte frame, transfer, next-frame byte, ack, reset.
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 8'h11, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 8'h22, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 8'h33, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 8'h44, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 8'h55, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 8'h66, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 8'h77, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 8'h88, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 8'h00, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 8'h00, 1, 0, 1};
    tbl[11] = '{0, 1, 0, 8'h99, 1, 0, 1};
    tbl[12] = '{0, 0, 1, 8'h00, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 8'h00, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 8'h00, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].rst, tbl[i].rdy, tbl[i].d, 0, tbl[i].ack);
      check($sformatf("tbl[%0d] Frame_ready", i), Frame_ready, tbl[i].e_ready);
      check($sformatf("tbl[%0d] Load", i), Load_frame_datareg, tbl[i].e_load);
      if (tbl[i].chk_data) begin
        check($sformatf("tbl[%0d] data", i), can_tx_data_bus, 64'h1122334455667788);
        check($sformatf("tbl[%0d] dlc", i), frame_dlc, 4'd8);
      end
    end
    check_reset_outputs("after table reset");

    // Slow byte stream, no ack: exactly one load pulse and a held frame.
    tick(1, 0, 8'h00, 0, 0);
    load_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i * 8'h11));
      idle(3);
    end
    idle(6);
    check("slow load pulse count", 64'(load_seen), 64'd1);
    check("slow data", can_tx_data_bus, 64'h1122334455667788);
    check("slow dlc", frame_dlc, 4'd8);
    check("slow Frame_ready held", Frame_ready, 1'b1);
    check("slow Can_ID_Bus", Can_ID_Bus, CAN_ID);

    // Frame pending: fill assembly, ninth byte overruns, ack releases the second frame.
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'hAA);
    check("overrun set", overrun, 1'b1);
    tick(0, 0, 8'h00, 0, 1);
    check("ack clears Frame_ready", Frame_ready, 1'b0);
    idle(1);
    check("second frame ready", Frame_ready, 1'b1);
    check("second frame load", Load_frame_datareg, 1'b1);
    check("second frame data", can_tx_data_bus, 64'h0102030405060708);
    idle(4);
    check("overrun sticky", overrun, 1'b1);

    // Partial frame followed by idle ticks.
    tick(1, 0, 8'h00, 0, 0);
    send(8'hDE);
    send(8'hAD);
    for (int i = 0; i < TIMEOUT_TICKS; i++) tick(0, 0, 8'h00, 1, 0);
    idle(1);
`ifdef FRAME_TIMEOUT_EN
    check("timeout Frame_ready", Frame_ready, 1'b1);
    check("timeout data", can_tx_data_bus, 64'hDEAD000000000000);
    check("timeout dlc", frame_dlc, 4'd2);
`else
    check("no-timeout Frame_ready", Frame_ready, 1'b0);
    for (int i = 1; i <= 6; i++) send(8'(i));
    idle(1);
    check("no-timeout Frame_ready", Frame_ready, 1'b1);
    check("no-timeout data", can_tx_data_bus, 64'hDEAD010203040506);
    check("no-timeout dlc", frame_dlc, 4'd8);
`endif

    // Reset mid-frame and with a frame held.
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i));
    tick(1, 0, 8'h00, 0, 0);
    check_reset_outputs("reset mid-frame");
    for (int i = 1; i <= 8; i++) send(8'hA0 + 8'(i));
    idle(1);
    check("clean frame data", can_tx_data_bus, 64'hA1A2A3A4A5A6A7A8);
    check("clean frame ready", Frame_ready, 1'b1);
    for (int i = 1; i <= 8; i++) send(8'hB0 + 8'(i));
    tick(1, 0, 8'h00, 0, 0);
    check_reset_outputs("reset with frame held");
    idle(3);
    check("no load after reset", Load_frame_datareg, 1'b0);
    check("no frame after reset", Frame_ready, 1'b0);

    // Byte arriving in the transfer cycle becomes byte 0 of the next frame.
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    send(8'h5A);
    check("xfer-cycle load", Load_frame_datareg, 1'b1);
    check("xfer-cycle data", can_tx_data_bus, 64'h1011121314151617);
    check("xfer-cycle no overrun", overrun, 1'b0);
    tick(0, 0, 8'h00, 0, 1);
    for (int i = 1; i <= 7; i++) send(8'h60 + 8'(i));
    idle(1);
    check("next frame byte0", can_tx_data_bus[63:56], 8'h5A);
    check("next frame data", can_tx_data_bus, 64'h5A61626364656667);

    // Randomized traffic against the model.
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 99) < 45),
           8'($urandom),
           ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
